multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 72 +++++++
 rtl/alu_mul_iter.sv | 78 +++++++
 rtl/multicycle_alu.sv | 141 ++++++++++++++
 tb/tb_multicycle_alu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multicycle ALU: alu_op values, R-type {funct7, funct3}
// decode constants, the internal operation and state enums, and the decode helper.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    localparam logic [9:0] FN_ADD  = 10'b0000000_000;
    localparam logic [9:0] FN_SUB  = 10'b0100000_000;
    localparam logic [9:0] FN_AND  = 10'b0000000_111;
    localparam logic [9:0] FN_OR   = 10'b0000000_110;
    localparam logic [9:0] FN_XOR  = 10'b0000000_100;
    localparam logic [9:0] FN_SLL  = 10'b0000000_001;
    localparam logic [9:0] FN_SRL  = 10'b0000000_101;
    localparam logic [9:0] FN_SRA  = 10'b0100000_101;
    localparam logic [9:0] FN_SLT  = 10'b0000000_010;
    localparam logic [9:0] FN_SLTU = 10'b0000000_011;
    localparam logic [9:0] FN_MUL  = 10'b0000001_000;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_SLT,
        OP_SLTU,
        OP_MUL,
        OP_ILLEGAL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_e;

    function automatic op_e decode_op(input logic [1:0] alu_op,
                                      input logic [6:0] funct7,
                                      input logic [2:0] funct3);
        op_e op;
        op = OP_ILLEGAL;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_RTYPE: begin
                case ({funct7, funct3})
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_XOR:  op = OP_XOR;
                    FN_SLL:  op = OP_SLL;
                    FN_SRL:  op = OP_SRL;
                    FN_SRA:  op = OP_SRA;
                    FN_SLT:  op = OP_SLT;
                    FN_SLTU: op = OP_SLTU;
                    FN_MUL:  op = OP_MUL;
                    default: op = OP_ILLEGAL;
                endcase
            end
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, N cycles per product.
// product is the combinational next accumulator value and is meaningful while done is high.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  step;
    logic          last_step;

    // Partial products beyond bit N-1 fall off the shifted multiplicand, so the
    // accumulator naturally keeps only the low N bits of the product.
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        step      = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step = busy_q && (cnt_q == LAST);
        if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (last_step) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last_step;
    assign product = step;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle RISC-V style ops plus an N-cycle iterative MUL.
// Handshake: a request moves on in_valid && in_ready; a result moves on out_valid && out_ready.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int INSTRUCTION_ADDR_SIZE = 5,
    parameter int N = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [(2**INSTRUCTION_ADDR_SIZE)-1:0] instruction,
    input  logic [1:0]                          alu_op,
    input  logic [N-1:0]                        data_1,
    input  logic [N-1:0]                        data_2,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [N-1:0]                        data_out,
    output logic                                zero,
    output logic                                illegal
);

    localparam int IW = 2**INSTRUCTION_ADDR_SIZE;
    localparam int SW = $clog2(N);
    localparam logic [31:0] FIELD_MASK32 = 32'hFE00_7000;
    localparam logic [IW-1:0] FIELD_MASK = IW'(FIELD_MASK32);

    state_e        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic          zero_q, zero_d;
    logic          illegal_q, illegal_d;

    op_e           op;
    logic [N-1:0]  result;
    logic [SW-1:0] shamt;
    logic          accept;
    logic          mul_start;
    logic          mul_busy;
    logic          mul_done;
    logic [N-1:0]  mul_product;
    logic          unused_instr;

    assign unused_instr = ^(instruction & ~FIELD_MASK);

    assign op     = decode_op(alu_op, instruction[31:25], instruction[14:12]);
    assign shamt  = data_2[SW-1:0];
    assign accept = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = data_1 + data_2;
            OP_SUB:  result = data_1 - data_2;
            OP_AND:  result = data_1 & data_2;
            OP_OR:   result = data_1 | data_2;
            OP_XOR:  result = data_1 ^ data_2;
            OP_SLL:  result = data_1 << shamt;
            OP_SRL:  result = data_1 >> shamt;
            OP_SRA:  result = $unsigned($signed(data_1) >>> shamt);
            OP_SLT:  result = {{(N-1){1'b0}}, $signed(data_1) < $signed(data_2)};
            OP_SLTU: result = {{(N-1){1'b0}}, data_1 < data_2};
            default: result = '0;
        endcase
    end

    alu_mul_iter #(
        .N(N)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (data_1),
        .b       (data_2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Result registers only change when a new result is written, so they hold
    // through backpressure and stay put after the return to IDLE.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d   = ST_DONE;
                        data_d    = result;
                        zero_d    = (result == '0);
                        illegal_d = (op == OP_ILLEGAL);
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d   = ST_DONE;
                    data_d    = mul_product;
                    zero_d    = (mul_product == '0);
                    illegal_d = 1'b0;
                end else if (!mul_busy) begin
                    // Multiplier not running: nothing to wait for, drop back to IDLE.
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign data_out  = data_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: drivers push expected results into a queue,
// a negedge monitor pops and compares whenever a new result is presented.
module tb_multicycle_alu;

    localparam int N = 64;
    localparam int IAS = 5;

    localparam logic [31:0] I_ADD  = 32'h0000_0033;
    localparam logic [31:0] I_SUB  = 32'h4000_0033;
    localparam logic [31:0] I_AND  = 32'h0000_7033;
    localparam logic [31:0] I_OR   = 32'h0000_6033;
    localparam logic [31:0] I_XOR  = 32'h0000_4033;
    localparam logic [31:0] I_SLL  = 32'h0000_1033;
    localparam logic [31:0] I_SRL  = 32'h0000_5033;
    localparam logic [31:0] I_SRA  = 32'h4000_5033;
    localparam logic [31:0] I_SLT  = 32'h0000_2033;
    localparam logic [31:0] I_SLTU = 32'h0000_3033;
    localparam logic [31:0] I_MUL  = 32'h0200_0033;
    localparam logic [31:0] I_BAD  = 32'h0200_1033;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instruction;
    logic [1:0]   alu_op;
    logic [N-1:0] data_1;
    logic [N-1:0] data_2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] data_out;
    logic         zero;
    logic         illegal;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Scoreboard: {illegal, zero, data_out}, cycle the result must appear, MUL-state cycles.
    logic [N+1:0] exp_q[$];
    int           cyc_q[$];
    int           dly_q[$];

    int           prev_acc = -10;
    logic [N+1:0] held;
    logic         prev_valid = 1'b0;
    int           mul_run = 0;

    multicycle_alu #(
        .INSTRUCTION_ADDR_SIZE(IAS),
        .N(N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .alu_op      (alu_op),
        .data_1      (data_1),
        .data_2      (data_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .zero        (zero),
        .illegal     (illegal)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [N+1:0] act, input logic [N+1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: present a request, wait (bounded) for acceptance, record expectation
    task automatic send(input logic [1:0] op, input logic [31:0] instr,
                        input logic [N-1:0] d1, input logic [N-1:0] d2,
                        input logic [N-1:0] exp_data, input logic exp_ill, input int delay);
        int waited;
        int acc;
        @(negedge clk);
        in_valid    = 1'b1;
        alu_op      = op;
        instruction = instr;
        data_1      = d1;
        data_2      = d2;
        waited      = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 after 200 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        check("accept_spacing_ge2", (N+2)'(acc - prev_acc >= 2), (N+2)'(1));
        exp_q.push_back({exp_ill, (exp_data == '0), exp_data});
        cyc_q.push_back(acc + delay);
        dly_q.push_back(delay);
        prev_acc = acc;
        @(negedge clk);
        // Scramble inputs after acceptance; the captured request must be unaffected.
        in_valid    = 1'b0;
        alu_op      = ~op;
        instruction = ~instr;
        data_1      = ~d1;
        data_2      = d2 ^ 64'h5A5A_5A5A_5A5A_5A5A;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", (N+2)'(exp_q.size()), '0);
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            mul_run    = 0;
        end else begin
            if (in_ready) mul_run = 0;
            else if (!out_valid) mul_run++;
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: got %h, required no result", data_out);
                end else begin
                    check("result", {illegal, zero, data_out}, exp_q.pop_front());
                    check("valid_cycle", (N+2)'(cyc), (N+2)'(cyc_q.pop_front()));
                    check("in_ready_low_cycles", (N+2)'(mul_run), (N+2)'(dly_q.pop_front()));
                end
                held = {illegal, zero, data_out};
            end else if (out_valid) begin
                check("stable_under_backpressure", {illegal, zero, data_out}, held);
            end else if (prev_valid) begin
                check("retained_after_done", {illegal, zero, data_out}, held);
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int seen;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_op      = 2'b00;
        instruction = '0;
        data_1      = '0;
        data_2      = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", (N+2)'(in_ready), (N+2)'(1));
        check("reset_out_valid", (N+2)'(out_valid), '0);
        check("reset_outputs", {illegal, zero, data_out}, '0);
        rst_n = 1'b1;

        // ADD wrap to zero, alu_op add/sub paths
        send(2'b10, I_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 0);
        send(2'b00, I_SUB, 64'd7, 64'd8, 64'd15, 1'b0, 0);
        send(2'b01, I_ADD, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0);
        send(2'b10, I_SUB, 64'd100, 64'd1, 64'd99, 1'b0, 0);

        // shifts and logic
        send(2'b10, I_SRA, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 0);
        send(2'b10, I_SRL, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 1'b0, 0);
        send(2'b10, I_SLL, 64'd1, 64'h3F, 64'h8000_0000_0000_0000, 1'b0, 0);
        send(2'b10, I_AND, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 0);
        send(2'b10, I_OR, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0, 0);
        send(2'b10, I_XOR, 64'hFF, 64'h0F, 64'hF0, 1'b0, 0);
        send(2'b10, I_SLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        send(2'b10, I_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 0);

        // MUL
        send(2'b10, I_MUL, 64'h1_0000_0001, 64'h3, 64'h3_0000_0003, 1'b0, N);
        send(2'b10, I_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, N);

        // backpressure with ignored requests
        drain();
        out_ready = 1'b0;
        send(2'b00, I_ADD, 64'd7, 64'd8, 64'd15, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            alu_op   = 2'b00;
            data_1   = 64'(i + 1000);
            data_2   = 64'd3;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(2'b10, I_ADD, 64'd2, 64'd3, 64'd5, 1'b0, 0);

        // illegal, undecoded R-type, SLT
        send(2'b11, I_ADD, 64'd9, 64'd9, 64'd0, 1'b1, 0);
        send(2'b10, I_BAD, 64'd9, 64'd9, 64'd0, 1'b1, 0);
        send(2'b10, I_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 0);
        drain();

        // reset mid-MUL
        @(negedge clk);
        in_valid    = 1'b1;
        alu_op      = 2'b10;
        instruction = I_MUL;
        data_1      = 64'd12345;
        data_2      = 64'd678;
        check("mul_req_ready", (N+2)'(in_ready), (N+2)'(1));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_mul_busy", (N+2)'(in_ready), '0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_mul_out_valid", (N+2)'(out_valid), '0);
        check("reset_mid_mul_in_ready", (N+2)'(in_ready), (N+2)'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_result_after_reset", (N+2)'(seen), '0);

        // first edge after reset release accepts
        @(negedge clk);
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        alu_op      = 2'b00;
        instruction = I_ADD;
        data_1      = 64'd40;
        data_2      = 64'd2;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 64'd42});
        cyc_q.push_back(cyc + 1);
        dly_q.push_back(0);
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
